// File: rtl/k_fifo_ctrl_if.sv
// k_fifo_ctrl_if: push/pop side of the FIFO controller (requests, data and status)
interface k_fifo_ctrl_if #(
    parameter int data_size = 8,
    parameter int addr_size = 1
);
    logic                 push;
    logic                 pop;
    logic                 clr_err;
    logic [data_size-1:0] din;
    logic [data_size-1:0] dout;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic [addr_size:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output push, pop, clr_err, din,
        input  dout, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, clr_err, din,
        output dout, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/k_fifo_ctrl.sv
// k_fifo_ctrl: single-clock FWFT FIFO controller driving an external dual-port RAM
module k_fifo_ctrl #(
    parameter int data_size = 8,
    parameter int addr_size = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    k_fifo_ctrl_if.slave         bus,
    output logic                 ram_wen,
    output logic [addr_size-1:0] ram_waddr,
    output logic [addr_size-1:0] ram_raddr,
    output logic [data_size-1:0] ram_d,
    input  logic [data_size-1:0] ram_q
);
    localparam int depth = 2 ** addr_size;

    logic [addr_size-1:0] wptr;
    logic [addr_size-1:0] rptr;
    logic [addr_size:0]   count;
    logic                 overflow;
    logic                 underflow;
    logic                 full;
    logic                 empty;
    logic                 push_acc;
    logic                 pop_acc;

    // status decoded only from the count register, plus accept qualifiers and RAM port wiring
    always_comb begin
        full            = (count == (addr_size+1)'(depth));
        empty           = (count == '0);
        push_acc        = bus.push && !full;
        pop_acc         = bus.pop && !empty;
        ram_wen         = push_acc;
        ram_waddr       = wptr;
        ram_raddr       = rptr;
        ram_d           = bus.din;
        bus.dout        = ram_q;
        bus.full        = full;
        bus.empty       = empty;
        bus.almost_full = (count >= (addr_size+1)'(depth - 1));
        bus.count       = count;
        bus.overflow    = overflow;
        bus.underflow   = underflow;
    end

    // pointers wrap naturally modulo depth; count moves only when exactly one side is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_acc) wptr <= wptr + 1'b1;
            if (pop_acc) rptr <= rptr + 1'b1;
            if (push_acc != pop_acc) count <= push_acc ? count + 1'b1 : count - 1'b1;
        end
    end

    // sticky error flags; a new offending request beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (bus.push && full) ? 1'b1 : (bus.clr_err ? 1'b0 : overflow);
            underflow <= (bus.pop && empty) ? 1'b1 : (bus.clr_err ? 1'b0 : underflow);
        end
    end
endmodule

// File: tb/tb_k_fifo_ctrl.sv
// tb_k_fifo_ctrl: directed checks of the FIFO controller at depth 2 and depth 8
module tb_k_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    k_fifo_ctrl_if #(.data_size(8), .addr_size(1)) ia ();
    k_fifo_ctrl_if #(.data_size(8), .addr_size(3)) ib ();

    logic       wen_a, wen_b;
    logic [0:0] wa_a, ra_a;
    logic [2:0] wa_b, ra_b;
    logic [7:0] d_a, q_a, d_b, q_b;
    logic [7:0] mem_a [2];
    logic [7:0] mem_b [8];

    k_fifo_ctrl #(.data_size(8), .addr_size(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia), .ram_wen(wen_a), .ram_waddr(wa_a),
        .ram_raddr(ra_a), .ram_d(d_a), .ram_q(q_a)
    );

    k_fifo_ctrl #(.data_size(8), .addr_size(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib), .ram_wen(wen_b), .ram_waddr(wa_b),
        .ram_raddr(ra_b), .ram_d(d_b), .ram_q(q_b)
    );

    always @(posedge clk) if (wen_a) mem_a[wa_a] <= d_a;
    always @(posedge clk) if (wen_b) mem_b[wa_b] <= d_b;
    assign q_a = mem_a[ra_a];
    assign q_b = mem_b[ra_b];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ia.push = 1'b1; ia.din = 8'h5A;
        step();
        ia.push = 1'b0;
        total++; if (ia.count !== 2'd1) begin bad++; $display("FAIL rst_pre_count got=%0d exp=1", ia.count); end
        total++; if (wa_a !== 1'b1) begin bad++; $display("FAIL rst_pre_waddr got=%0d exp=1", wa_a); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (ia.count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", ia.count); end
        total++; if (ia.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b exp=1", ia.empty); end
        total++; if (ia.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b exp=0", ia.full); end
        total++; if (ia.almost_full !== 1'b0) begin bad++; $display("FAIL rst_afull got=%0b exp=0", ia.almost_full); end
        total++; if (ia.overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b exp=0", ia.overflow); end
        total++; if (ia.underflow !== 1'b0) begin bad++; $display("FAIL rst_udf got=%0b exp=0", ia.underflow); end
        total++; if (ra_a !== 1'b0) begin bad++; $display("FAIL rst_raddr got=%0d exp=0", ra_a); end
        total++; if (wa_a !== 1'b0) begin bad++; $display("FAIL rst_waddr got=%0d exp=0", wa_a); end
        total++; if (wen_a !== 1'b0) begin bad++; $display("FAIL rst_wen got=%0b exp=0", wen_a); end
        total++; if (ib.empty !== 1'b1) begin bad++; $display("FAIL rst_b_empty got=%0b exp=1", ib.empty); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        ia.push = 1'b1; ia.din = 8'hA5;
        step();
        total++; if (ia.count !== 2'd1) begin bad++; $display("FAIL fd_count1 got=%0d exp=1", ia.count); end
        total++; if (ia.empty !== 1'b0) begin bad++; $display("FAIL fd_empty1 got=%0b exp=0", ia.empty); end
        total++; if (ia.dout !== 8'hA5) begin bad++; $display("FAIL fd_dout1 got=%0h exp=a5", ia.dout); end
        total++; if (ia.almost_full !== 1'b1) begin bad++; $display("FAIL fd_afull1 got=%0b exp=1", ia.almost_full); end
        ia.din = 8'h3C;
        step();
        ia.push = 1'b0;
        total++; if (ia.full !== 1'b1) begin bad++; $display("FAIL fd_full got=%0b exp=1", ia.full); end
        total++; if (ia.almost_full !== 1'b1) begin bad++; $display("FAIL fd_afull2 got=%0b exp=1", ia.almost_full); end
        total++; if (ia.count !== 2'd2) begin bad++; $display("FAIL fd_count2 got=%0d exp=2", ia.count); end
        total++; if (ia.dout !== 8'hA5) begin bad++; $display("FAIL fd_head1 got=%0h exp=a5", ia.dout); end
        ia.pop = 1'b1;
        step();
        total++; if (ia.dout !== 8'h3C) begin bad++; $display("FAIL fd_head2 got=%0h exp=3c", ia.dout); end
        total++; if (ia.count !== 2'd1) begin bad++; $display("FAIL fd_count3 got=%0d exp=1", ia.count); end
        total++; if (ia.full !== 1'b0) begin bad++; $display("FAIL fd_full2 got=%0b exp=0", ia.full); end
        step();
        ia.pop = 1'b0;
        total++; if (ia.empty !== 1'b1) begin bad++; $display("FAIL fd_empty2 got=%0b exp=1", ia.empty); end
        total++; if (ia.underflow !== 1'b0) begin bad++; $display("FAIL fd_udf got=%0b exp=0", ia.underflow); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 5; i++) begin
            ia.push = 1'b1; ia.din = 8'(i);
            step();
            ia.push = 1'b0;
            total++; if (ia.dout !== 8'(i)) begin bad++; $display("FAIL wrap_dout%0d got=%0h exp=%0h", i, ia.dout, i); end
            total++; if (wa_a !== 1'(i % 2)) begin bad++; $display("FAIL wrap_waddr%0d got=%0d exp=%0d", i, wa_a, i % 2); end
            ia.pop = 1'b1;
            step();
            ia.pop = 1'b0;
            total++; if (ia.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty%0d got=%0b exp=1", i, ia.empty); end
            total++; if (ra_a !== 1'(i % 2)) begin bad++; $display("FAIL wrap_raddr%0d got=%0d exp=%0d", i, ra_a, i % 2); end
        end
    endtask

    task automatic test_simultaneous();
        ia.push = 1'b1; ia.din = 8'h11;
        step();
        ia.din = 8'h22; ia.pop = 1'b1;
        step();
        total++; if (ia.count !== 2'd1) begin bad++; $display("FAIL sim_count1 got=%0d exp=1", ia.count); end
        total++; if (ia.dout !== 8'h22) begin bad++; $display("FAIL sim_head1 got=%0h exp=22", ia.dout); end
        ia.din = 8'h33; ia.pop = 1'b0;
        step();
        total++; if (ia.full !== 1'b1) begin bad++; $display("FAIL sim_full got=%0b exp=1", ia.full); end
        ia.din = 8'h44; ia.pop = 1'b1;
        #1;
        total++; if (wen_a !== 1'b0) begin bad++; $display("FAIL sim_wen_full got=%0b exp=0", wen_a); end
        step();
        ia.push = 1'b0;
        total++; if (ia.count !== 2'd1) begin bad++; $display("FAIL sim_count2 got=%0d exp=1", ia.count); end
        total++; if (ia.overflow !== 1'b1) begin bad++; $display("FAIL sim_ovf got=%0b exp=1", ia.overflow); end
        total++; if (ia.dout !== 8'h33) begin bad++; $display("FAIL sim_head2 got=%0h exp=33", ia.dout); end
        step();
        ia.pop = 1'b0;
        total++; if (ia.empty !== 1'b1) begin bad++; $display("FAIL sim_empty got=%0b exp=1", ia.empty); end
        ia.clr_err = 1'b1;
        step();
        ia.clr_err = 1'b0;
        total++; if (ia.overflow !== 1'b0) begin bad++; $display("FAIL sim_ovf_clr got=%0b exp=0", ia.overflow); end
    endtask

    task automatic test_errors();
        logic [0:0] ra0;
        ra0 = ra_a;
        ia.pop = 1'b1;
        step();
        total++; if (ia.underflow !== 1'b1) begin bad++; $display("FAIL err_udf got=%0b exp=1", ia.underflow); end
        total++; if (ia.count !== 2'd0) begin bad++; $display("FAIL err_count got=%0d exp=0", ia.count); end
        total++; if (ra_a !== ra0) begin bad++; $display("FAIL err_raddr got=%0d exp=%0d", ra_a, ra0); end
        ia.clr_err = 1'b1;
        step();
        total++; if (ia.underflow !== 1'b1) begin bad++; $display("FAIL err_set_wins got=%0b exp=1", ia.underflow); end
        ia.pop = 1'b0;
        step();
        ia.clr_err = 1'b0;
        total++; if (ia.underflow !== 1'b0) begin bad++; $display("FAIL err_clr got=%0b exp=0", ia.underflow); end
        total++; if (ia.overflow !== 1'b0) begin bad++; $display("FAIL err_ovf got=%0b exp=0", ia.overflow); end
    endtask

    task automatic test_depth8();
        ib.push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ib.din = 8'(8'h80 + i);
            step();
            total++; if (ib.count !== 4'(i + 1)) begin bad++; $display("FAIL d8_count%0d got=%0d exp=%0d", i, ib.count, i + 1); end
            total++; if (ib.almost_full !== (i + 1 >= 7)) begin bad++; $display("FAIL d8_afull%0d got=%0b exp=%0b", i, ib.almost_full, i + 1 >= 7); end
            total++; if (ib.full !== (i + 1 == 8)) begin bad++; $display("FAIL d8_full%0d got=%0b exp=%0b", i, ib.full, i + 1 == 8); end
        end
        ib.push = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (ib.dout !== 8'(8'h80 + i)) begin bad++; $display("FAIL d8_drain%0d got=%0h exp=%0h", i, ib.dout, 8'h80 + i); end
            ib.pop = 1'b1;
            step();
            ib.pop = 1'b0;
        end
        total++; if (ib.empty !== 1'b1) begin bad++; $display("FAIL d8_empty got=%0b exp=1", ib.empty); end
        ib.push = 1'b1; ib.din = 8'hC0;
        step();
        ib.pop = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++; if (ib.dout !== 8'(8'hC0 + i - 1)) begin bad++; $display("FAIL b2b_head%0d got=%0h exp=%0h", i, ib.dout, 8'hC0 + i - 1); end
            ib.din = 8'(8'hC0 + i);
            step();
            total++; if (ib.count !== 4'd1 || ib.empty !== 1'b0 || ib.full !== 1'b0) begin bad++; $display("FAIL b2b_flags%0d got=%0d/%0b/%0b exp=1/0/0", i, ib.count, ib.empty, ib.full); end
        end
        ib.push = 1'b0;
        total++; if (ib.dout !== 8'hC8) begin bad++; $display("FAIL b2b_last got=%0h exp=c8", ib.dout); end
        step();
        ib.pop = 1'b0;
        total++; if (ib.empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%0b exp=1", ib.empty); end
        total++; if (ib.overflow !== 1'b0 || ib.underflow !== 1'b0) begin bad++; $display("FAIL b2b_err got=%0b/%0b exp=0/0", ib.overflow, ib.underflow); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        ia.push = 1'b0; ia.pop = 1'b0; ia.clr_err = 1'b0; ia.din = 8'h00;
        ib.push = 1'b0; ib.pop = 1'b0; ib.clr_err = 1'b0; ib.din = 8'h00;
        #12 rst_n = 1'b1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_errors();
        test_depth8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/k_fifo_ctrl.md
# k_fifo_ctrl

Single-clock FIFO controller that drives a 2^addr_size-entry dual-port RAM with a combinational read port. It owns the write and read pointers, occupancy count, status flags and sticky error flags. It presents a first-word-fall-through push/pop interface to the surrounding logic. Data passes through unregistered: din goes to the RAM write data, and the RAM read data goes to dout.

## Interface
- data_size, 8: data word width in bits.
- addr_size, 1: RAM address width; depth = 2**addr_size (default 2 entries).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  write request.
- din  in  data_size  write data.
- pop  in  1  read request; consumes the word on dout.
- clr_err  in  1  clears sticky error flags.
- dout  out  data_size  head-of-FIFO word; equals ram_q.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= depth-1.
- count  out  addr_size+1  occupancy, 0..depth.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.
- ram_wen  out  1  RAM write enable.
- ram_waddr  out  addr_size  RAM write address (write pointer).
- ram_raddr  out  addr_size  RAM read address (read pointer).
- ram_d  out  data_size  RAM write data; equals din.
- ram_q  in  data_size  RAM combinational read data.

## Operation
- Accept conditions:
  - push_acc = push && !full
  - pop_acc = pop && !empty
  - Both use registered flags from the start of the cycle.
- ram_wen = push_acc, combinational. ram_waddr = wptr. ram_raddr = rptr.
- On a clock edge with push_acc, wptr advances by 1 and wraps from depth-1 to 0. This is natural modulo 2**addr_size.
- On a clock edge with pop_acc, rptr advances the same way.
- Count update:
  - push_acc only: count+1.
  - pop_acc only: count-1.
  - Both, or neither: unchanged.
- Simultaneous push and pop:
  - Full: pop is accepted, push is rejected and sets overflow. There is no same-cycle bypass.
  - Empty: push is accepted, pop is rejected and sets underflow. Data does not fall through in the same cycle.
  - Otherwise: both are accepted and count is unchanged.
- full, empty and almost_full are decoded combinationally from the count register.
- A rejected push or pop leaves the pointers, count and RAM unchanged.
- Error flags:
  - overflow sets on push && full. underflow sets on pop && empty.
  - Both hold until clr_err.
  - If a set and clr_err occur in the same cycle, the set wins.
- dout is valid only while !empty. Its value while empty is unspecified.
- Internal state is the registered pointers, count and error flags. There is no other FSM.

## Timing
- Reset is asynchronous and takes effect immediately, including mid-operation. Reset values:
  - wptr = 0, rptr = 0, count = 0.
  - empty = 1, full = 0, almost_full = 0 (if depth > 1).
  - overflow = 0, underflow = 0.
  - ram_wen = 0 while push is low. ram_wen stays combinational from push during reset, because full = 0.
- RAM contents are not reset. Stale data is never exposed, because empty = 1.
- Push-to-visible latency is one clock. A word pushed at edge N is on dout, with empty = 0, after edge N.
- Pop takes effect at the edge. After the edge, dout shows the next word, or the FIFO is empty.
- Flags and count change only at clock edges. They are never combinational from push or pop.
- Sticky error flags assert one clock after the offending request.
- The controller adds no combinational path from push or pop to full, empty or count. The only combinational paths are push to ram_wen, din to ram_d, and ram_q to dout.

## Test plan
- Reset: assert rst_n = 0 mid-cycle while count = 1 -> immediately count = 0, empty = 1, full = 0, overflow = 0, underflow = 0, ram_raddr = 0, ram_waddr = 0.
- Fill and drain at default depth 2:
  - Push 0xA5, then 0x3C -> after the second edge, full = 1, almost_full = 1, count = 2.
  - Pop twice -> dout reads 0xA5, then 0x3C; empty = 1 after the second pop.
- Wrap-around: run 5 alternating push/pop pairs with values 0x01..0x05 -> each value appears on dout one cycle after its push, and pointers wrap 0→1→0 with no data loss.
- Simultaneous push and pop:
  - At count = 1: push and pop together -> count stays 1; the old head pops and the new word becomes head.
  - When full: push and pop together -> count = 1, overflow = 1, and the rejected word is never read.
- Errors: pop while empty -> underflow = 1, and count and rptr stay unchanged. Assert clr_err together with a new pop-while-empty -> underflow stays 1. Assert clr_err alone -> underflow = 0.
- Parameter sweep with addr_size = 3: push 8 words -> full = 1; almost_full asserts at count = 7. Then push 9 words back-to-back against continuous pops -> in-order data and no flag glitches.
